// File: rtl/data_collector_seq.sv
// Sequencer for a sample collector on a strobe bus: configures channels,
// arms capture, polls TRIG_EN until capture ends, then streams each channel.
module data_collector_seq #(
    parameter int BUS_ADDR_WIDTH   = 16,
    parameter int BASE_ADDR        = 0,
    parameter int NUM_PORTS        = 1,
    parameter int DATA_WIDTH       = 16,
    parameter int SOFT_RESETN_OFFS = 0,
    parameter int BUS_CHAN_OFFS    = 5,
    parameter int TRIG_EN_OFFS     = 6,
    parameter int WR_PERM_OFFS     = 7,
    parameter int WR_DEPTH_OFFS    = 8,
    parameter int RAM_OFFS         = 10,
    parameter int POLL_GAP         = 8,
    parameter int POLL_MAX         = 65535,
    parameter int RV_TIMEOUT       = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_PORTS-1:0]      chan_mask,
    input  logic [15:0]               depth,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                err,
    output logic [BUS_ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]               m_wdata,
    output logic                      m_wr,
    output logic                      m_rd,
    input  logic [31:0]               m_rdata,
    input  logic                      m_rvalid,
    output logic [31:0]               out_data,
    output logic [3:0]                out_chan,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [BUS_ADDR_WIDTH-1:0] A_SRST  = BUS_ADDR_WIDTH'(BASE_ADDR + SOFT_RESETN_OFFS);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_CHAN  = BUS_ADDR_WIDTH'(BASE_ADDR + BUS_CHAN_OFFS);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_TRIG  = BUS_ADDR_WIDTH'(BASE_ADDR + TRIG_EN_OFFS);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_PERM  = BUS_ADDR_WIDTH'(BASE_ADDR + WR_PERM_OFFS);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_DEPTH = BUS_ADDR_WIDTH'(BASE_ADDR + WR_DEPTH_OFFS);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_RAM   = BUS_ADDR_WIDTH'(BASE_ADDR + RAM_OFFS);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_CHAN,
        ST_CFG_PERM,
        ST_CFG_DEPTH,
        ST_ARM,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_POLL_GAP,
        ST_RD_SEL,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_OUT,
        ST_SRST,
        ST_FIN
    } state_t;

    state_t state, state_n;

    logic                      busy_n, done_n, wr_n, rd_n;
    logic [1:0]                err_n;
    logic [BUS_ADDR_WIDTH-1:0] addr_n;
    logic [31:0]               wdata_n, out_data_n;
    logic [3:0]                out_chan_n, cur_chan, cur_chan_n;
    logic                      out_last_n, out_valid_n;
    logic [15:0]               mask_q, mask_n, depth_q, depth_n;
    logic [4:0]                ch_idx, ch_idx_n;
    logic [15:0]               word_cnt, word_n, poll_cnt, poll_n;
    logic [15:0]               gap_cnt, gap_n, tmo_cnt, tmo_n;
    logic                      sel_found;
    logic [3:0]                sel_chan;
    logic                      unused_rdata;

    assign unused_rdata = ^m_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 2'd0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wr      <= 1'b0;
            m_rd      <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            cur_chan  <= '0;
            mask_q    <= '0;
            depth_q   <= '0;
            ch_idx    <= '0;
            word_cnt  <= '0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            m_addr    <= addr_n;
            m_wdata   <= wdata_n;
            m_wr      <= wr_n;
            m_rd      <= rd_n;
            out_data  <= out_data_n;
            out_chan  <= out_chan_n;
            out_last  <= out_last_n;
            out_valid <= out_valid_n;
            cur_chan  <= cur_chan_n;
            mask_q    <= mask_n;
            depth_q   <= depth_n;
            ch_idx    <= ch_idx_n;
            word_cnt  <= word_n;
            poll_cnt  <= poll_n;
            gap_cnt   <= gap_n;
            tmo_cnt   <= tmo_n;
        end
    end

    always_comb begin
        state_n     = state;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = err;
        addr_n      = m_addr;
        wdata_n     = m_wdata;
        wr_n        = 1'b0;
        rd_n        = 1'b0;
        out_data_n  = out_data;
        out_chan_n  = out_chan;
        out_last_n  = out_last;
        out_valid_n = out_valid;
        cur_chan_n  = cur_chan;
        mask_n      = mask_q;
        depth_n     = depth_q;
        ch_idx_n    = ch_idx;
        word_n      = word_cnt;
        poll_n      = poll_cnt;
        gap_n       = gap_cnt;
        tmo_n       = tmo_cnt;
        sel_found   = 1'b0;
        sel_chan    = '0;

        // lowest enabled channel at or above ch_idx
        for (int i = 0; i < 16; i++) begin
            if (!sel_found && mask_q[i] && (5'(i) >= ch_idx)) begin
                sel_found = 1'b1;
                sel_chan  = 4'(i);
            end
        end

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_n   = 1'b1;
                    err_n    = 2'd0;
                    mask_n   = 16'(chan_mask);
                    depth_n  = depth;
                    ch_idx_n = '0;
                    if (chan_mask == '0 || depth == 16'd0)
                        state_n = ST_FIN;
                    else
                        state_n = ST_CFG_CHAN;
                end
            end
            ST_CFG_CHAN: begin
                wr_n    = 1'b1;
                addr_n  = A_CHAN;
                wdata_n = 32'(ch_idx);
                state_n = ST_CFG_PERM;
            end
            ST_CFG_PERM: begin
                wr_n    = 1'b1;
                addr_n  = A_PERM;
                wdata_n = {31'd0, mask_q[ch_idx[3:0]]};
                if (ch_idx == 5'(NUM_PORTS - 1)) begin
                    ch_idx_n = '0;
                    state_n  = ST_CFG_DEPTH;
                end else begin
                    ch_idx_n = ch_idx + 5'd1;
                    state_n  = ST_CFG_CHAN;
                end
            end
            ST_CFG_DEPTH: begin
                wr_n    = 1'b1;
                addr_n  = A_DEPTH;
                wdata_n = {16'd0, depth_q};
                state_n = ST_ARM;
            end
            ST_ARM: begin
                wr_n    = 1'b1;
                addr_n  = A_TRIG;
                wdata_n = 32'd1;
                poll_n  = '0;
                state_n = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                rd_n    = 1'b1;
                addr_n  = A_TRIG;
                tmo_n   = '0;
                state_n = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (m_rvalid) begin
                    if (!m_rdata[0]) begin
                        ch_idx_n = '0;
                        state_n  = ST_RD_SEL;
                    end else if (poll_cnt == 16'(POLL_MAX - 1)) begin
                        err_n   = 2'd2;
                        state_n = ST_SRST;
                    end else begin
                        poll_n  = poll_cnt + 16'd1;
                        gap_n   = '0;
                        state_n = ST_POLL_GAP;
                    end
                end else if (tmo_cnt == 16'(RV_TIMEOUT - 1)) begin
                    err_n   = 2'd1;
                    state_n = ST_SRST;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            ST_POLL_GAP: begin
                if (32'(gap_cnt) + 32'd1 >= 32'(POLL_GAP))
                    state_n = ST_POLL_RD;
                else
                    gap_n = gap_cnt + 16'd1;
            end
            ST_RD_SEL: begin
                if (sel_found) begin
                    wr_n       = 1'b1;
                    addr_n     = A_CHAN;
                    wdata_n    = 32'(sel_chan);
                    cur_chan_n = sel_chan;
                    ch_idx_n   = {1'b0, sel_chan} + 5'd1;
                    word_n     = '0;
                    state_n    = ST_RD_REQ;
                end else begin
                    state_n = ST_FIN;
                end
            end
            ST_RD_REQ: begin
                rd_n    = 1'b1;
                addr_n  = A_RAM;
                tmo_n   = '0;
                state_n = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (m_rvalid) begin
                    out_data_n  = 32'(m_rdata[DATA_WIDTH-1:0]);
                    out_chan_n  = cur_chan;
                    out_last_n  = (word_cnt == depth_q - 16'd1);
                    out_valid_n = 1'b1;
                    state_n     = ST_OUT;
                end else if (tmo_cnt == 16'(RV_TIMEOUT - 1)) begin
                    err_n   = 2'd1;
                    state_n = ST_SRST;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    if (out_last) begin
                        state_n = ST_RD_SEL;
                    end else begin
                        word_n  = word_cnt + 16'd1;
                        state_n = ST_RD_REQ;
                    end
                end
            end
            ST_SRST: begin
                wr_n    = 1'b1;
                addr_n  = A_SRST;
                wdata_n = 32'd1;
                state_n = ST_FIN;
            end
            ST_FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
